// File: rtl/aes_state_seq.sv
// AES-128 state-matrix sequencer: column load, optional in-place ShiftRows, column unload.
// Latency start->done 12 cycles with ShiftRows, 9 without; start is ignored while busy (no queuing).
module aes_state_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         do_shift,
    input  logic [127:0] block_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] block_out,
    output logic [31:0]  mat_col_in,
    output logic [1:0]   mat_input_idx,
    output logic         mat_input_row_col,
    output logic         mat_write_enable,
    output logic [1:0]   mat_output_idx,
    output logic         mat_output_row_col,
    input  logic [31:0]  mat_out
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, UNLOAD, DONE} state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [127:0] blk_q;
    logic         shift_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            blk_q     <= '0;
            shift_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            block_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        blk_q   <= block_in;
                        shift_q <= do_shift;
                        cnt     <= 2'd0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        // ShiftRows leaves row 0 alone, so the shift pass starts at row 1
                        if (shift_q) begin
                            state <= SHIFT;
                            cnt   <= 2'd1;
                        end else begin
                            state <= UNLOAD;
                            cnt   <= 2'd0;
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= UNLOAD;
                end
                UNLOAD: begin
                    block_out[{~cnt, 5'd0} +: 32] <= mat_out;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Matrix port controls decode straight from state/cnt flops so reset clears them at once
    always_comb begin
        mat_col_in         = 32'd0;
        mat_input_idx      = 2'd0;
        mat_input_row_col  = 1'b0;
        mat_write_enable   = 1'b0;
        mat_output_idx     = 2'd0;
        mat_output_row_col = 1'b0;
        case (state)
            LOAD: begin
                mat_write_enable  = 1'b1;
                mat_input_row_col = 1'b1;
                mat_input_idx     = cnt;
                mat_col_in        = blk_q[{~cnt, 5'd0} +: 32];
            end
            SHIFT: begin
                mat_output_idx   = cnt;
                mat_input_idx    = cnt;
                mat_write_enable = 1'b1;
                case (cnt)
                    2'd1:    mat_col_in = {mat_out[23:0], mat_out[31:24]};
                    2'd2:    mat_col_in = {mat_out[15:0], mat_out[31:16]};
                    2'd3:    mat_col_in = {mat_out[7:0],  mat_out[31:8]};
                    default: mat_col_in = mat_out;
                endcase
            end
            UNLOAD: begin
                mat_output_row_col = 1'b1;
                mat_output_idx     = cnt;
            end
            default: ;
        endcase
    end

endmodule
